// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer
// Control FSM that walks one DSP48A1 slice through an N-tap multiply-accumulate
// job. A job descriptor (base address, tap count) is accepted in IDLE. One P
// register reset cycle follows. Operand reads are then issued one per cycle.
// A valid shift chain mirrors the slice's operand/M/P pipeline and drives the
// clock enables. When P holds the final sum, the result is presented on a
// valid/ready handshake.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. start_ready is high only in IDLE. res_valid and res_taps are
// held stable from the first DONE cycle until res_ready is seen.
//
// Ports:
//   clk, reset        clock; asynchronous active-high reset
//   start_valid/ready job descriptor handshake; start_base, start_len payload
//   mem_rd, mem_addr  operand read strobe/address (data returns next cycle)
//   dsp_ce_ab/m/p     slice register clock enables (ce_m held 0 when MREG=0)
//   dsp_rst_p         P register reset pulse (CLEAR state only)
//   dsp_opmode        ACC_OPMODE while a job is running, 0 otherwise
//   res_valid/ready   result handshake; res_taps = tap count of that job
//   busy              sequencer not in IDLE
//   dbg_state         current FSM state encoding
module dsp_mac_sequencer #(
  parameter int          ADDR_W     = 8,
  parameter int          LEN_W      = 8,
  parameter int          MREG       = 1,
  parameter logic [7:0]  ACC_OPMODE = 8'h09
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [ADDR_W-1:0] start_base,
  input  logic [LEN_W-1:0]  start_len,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              dsp_ce_ab,
  output logic              dsp_ce_m,
  output logic              dsp_ce_p,
  output logic              dsp_rst_p,
  output logic [7:0]        dsp_opmode,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [LEN_W-1:0]  res_taps,
  output logic              busy,
  output logic [2:0]        dbg_state
);

  // Chain length = pipeline depth from memory output to P register.
  localparam int CHAIN = (MREG != 0) ? 3 : 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FETCH = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [ADDR_W-1:0]  r_base;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_idx;
  logic [CHAIN-1:0]   r_vld;
  logic               w_fetch;
  logic               w_last_idx;
  logic               w_chain_empty_next;

  assign w_fetch    = (r_state == S_FETCH);
  assign w_last_idx = (r_idx == (r_len - LEN_W'(1)));
  // Everything upstream of the P enable is empty, so after this edge the
  // whole chain is clear and P holds the final sum.
  assign w_chain_empty_next = (r_vld[CHAIN-2:0] == '0);

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_base  <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_vld   <= '0;
    end else begin
      r_state <= w_next;
      r_vld   <= {r_vld[CHAIN-2:0], w_fetch};
      if ((r_state == S_IDLE) && start_valid) begin
        r_base <= start_base;
        r_len  <= start_len;
      end
      if (w_fetch) begin
        r_idx <= r_idx + LEN_W'(1);
      end else begin
        r_idx <= '0;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start_valid) w_next = S_CLEAR;
      S_CLEAR: w_next = (r_len != '0) ? S_FETCH : S_DONE;
      S_FETCH: if (w_last_idx) w_next = S_DRAIN;
      S_DRAIN: if (w_chain_empty_next) w_next = S_DONE;
      S_DONE:  if (res_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    start_ready = 1'b0;
    busy        = 1'b1;
    dsp_rst_p   = 1'b0;
    mem_rd      = 1'b0;
    mem_addr    = '0;
    dsp_opmode  = 8'h00;
    res_valid   = 1'b0;
    res_taps    = '0;
    case (r_state)
      S_IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
      end
      S_CLEAR: begin
        dsp_rst_p  = 1'b1;
        dsp_opmode = ACC_OPMODE;
      end
      S_FETCH: begin
        mem_rd     = 1'b1;
        // Address wraps modulo 2^ADDR_W.
        mem_addr   = r_base + ADDR_W'(r_idx);
        dsp_opmode = ACC_OPMODE;
      end
      S_DRAIN: begin
        dsp_opmode = ACC_OPMODE;
      end
      S_DONE: begin
        res_valid = 1'b1;
        res_taps  = r_len;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
    dsp_ce_ab = r_vld[0];
    dsp_ce_m  = (MREG != 0) ? r_vld[1] : 1'b0;
    dsp_ce_p  = r_vld[CHAIN-1];
    dbg_state = r_state;
  end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: instance 0 is built with MREG=1, instance 1 with
// MREG=0. Each instance has its own operand memory read port and slice model.
// A cycle-indexed job model predicts every output. A queue of expected sums
// is checked against the slice's P at each result handshake.
module tb_dsp_mac_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst, sv, rr, sr, mrd, ceab, cem, cep, rstp, rv, busy;
  logic [1:0][7:0]  sbase, slen, maddr, opm, rtaps;
  logic [1:0][2:0]  dbg;
  logic [1:0][31:0] p_w;

  logic [7:0]  a_mem [256];
  logic [7:0]  b_mem [256];

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  addr_log[$];

  // Job model state.
  logic       m_act  [2];
  int         m_k    [2];
  logic [7:0] m_base [2];
  logic [7:0] m_len  [2];

  // Results captured by run_job.
  int          lat_o;
  logic [31:0] p_o;
  logic [7:0]  taps_o;
  logic        saw_m_o;

  task automatic chk(input int g, input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL inst%0d %s actual=%0h required=%0h t=%0t", g, nm, act, req, $time);
    end
  endtask

  generate
    for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int GM = (g == 0) ? 1 : 0;
      logic [7:0]  mq_a, mq_b, a_r, b_r;
      logic [15:0] m_r;
      logic [15:0] prod;
      logic [31:0] p_r;
      logic [31:0] x_sel, z_sel;

      dsp_mac_sequencer #(
        .ADDR_W(8), .LEN_W(8), .MREG(GM), .ACC_OPMODE(8'h09)
      ) u_dut (
        .clk(clk), .reset(rst[g]),
        .start_valid(sv[g]), .start_ready(sr[g]),
        .start_base(sbase[g]), .start_len(slen[g]),
        .mem_rd(mrd[g]), .mem_addr(maddr[g]),
        .dsp_ce_ab(ceab[g]), .dsp_ce_m(cem[g]), .dsp_ce_p(cep[g]),
        .dsp_rst_p(rstp[g]), .dsp_opmode(opm[g]),
        .res_valid(rv[g]), .res_ready(rr[g]), .res_taps(rtaps[g]),
        .busy(busy[g]), .dbg_state(dbg[g])
      );

      // Slice model: operand regs, optional M reg, P = Z + X from OPMODE.
      // Registers sample mid-cycle so they never race the DUT's edge.
      assign prod  = 16'(a_r) * 16'(b_r);
      assign x_sel = (opm[g][1:0] == 2'b01) ? 32'((GM == 1) ? m_r : prod) : 32'd0;
      assign z_sel = (opm[g][3:2] == 2'b10) ? p_r : 32'd0;
      always @(negedge clk) begin
        if (rst[g]) begin
          mq_a <= '0; mq_b <= '0; a_r <= '0; b_r <= '0; m_r <= '0; p_r <= '0;
        end else begin
          if (mrd[g]) begin
            mq_a <= a_mem[maddr[g]];
            mq_b <= b_mem[maddr[g]];
          end
          if (ceab[g]) begin
            a_r <= mq_a;
            b_r <= mq_b;
          end
          if (cem[g]) m_r <= prod;
          if (rstp[g])     p_r <= '0;
          else if (cep[g]) p_r <= z_sel + x_sel;
        end
      end
      assign p_w[g] = p_r;
    end
  endgenerate

  function automatic int done_cycle(input int len, input int mreg);
    return (len == 0) ? 2 : len + 4 + mreg;
  endfunction

  // Job model: cycle k counts from the acceptance edge (k=1 is CLEAR).
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst[g]) begin
        if (m_act[g]) exp_q.delete();
        m_act[g] <= 1'b0;
        m_k[g]   <= 0;
      end else if (!m_act[g]) begin
        if (sv[g]) begin
          logic [31:0] s;
          s = 0;
          for (int t = 0; t < int'(slen[g]); t++) begin
            logic [7:0] ad;
            ad = sbase[g] + 8'(t);
            s  = s + 32'(a_mem[ad]) * 32'(b_mem[ad]);
          end
          exp_q.push_back(s);
          m_act[g]  <= 1'b1;
          m_k[g]    <= 1;
          m_base[g] <= sbase[g];
          m_len[g]  <= slen[g];
        end
      end else begin
        if (m_k[g] >= done_cycle(int'(m_len[g]), (g == 0) ? 1 : 0) && rr[g]) begin
          m_act[g] <= 1'b0;
        end else begin
          m_k[g] <= m_k[g] + 1;
        end
      end
    end
  end

  // Compare process: every output of both instances, every cycle.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      logic       e_sr, e_busy, e_rstp, e_mrd, e_ab, e_m, e_p, e_rv;
      logic [7:0] e_addr, e_op, e_taps;
      int         k, len, mr, dk;
      e_sr = 1'b1; e_busy = 1'b0; e_rstp = 1'b0; e_mrd = 1'b0;
      e_ab = 1'b0; e_m = 1'b0; e_p = 1'b0; e_rv = 1'b0;
      e_addr = 8'h00; e_op = 8'h00; e_taps = 8'h00;
      if (!rst[g] && m_act[g]) begin
        k   = m_k[g];
        len = int'(m_len[g]);
        mr  = (g == 0) ? 1 : 0;
        dk  = done_cycle(len, mr);
        e_sr   = 1'b0;
        e_busy = 1'b1;
        e_rstp = (k == 1);
        e_mrd  = (k >= 2) && (k <= len + 1);
        e_addr = e_mrd ? m_base[g] + 8'(k - 2) : 8'h00;
        e_ab   = (k >= 3) && (k <= len + 2);
        e_m    = (mr == 1) && (k >= 4) && (k <= len + 3);
        e_p    = (k >= 4 + mr) && (k <= len + 3 + mr);
        e_rv   = (k >= dk);
        e_op   = (k >= 1 && k < dk) ? 8'h09 : 8'h00;
        e_taps = e_rv ? m_len[g] : 8'h00;
      end
      chk(g, "start_ready", 32'(sr[g]), 32'(e_sr));
      chk(g, "busy", 32'(busy[g]), 32'(e_busy));
      chk(g, "dsp_rst_p", 32'(rstp[g]), 32'(e_rstp));
      chk(g, "mem_rd", 32'(mrd[g]), 32'(e_mrd));
      chk(g, "mem_addr", 32'(maddr[g]), 32'(e_addr));
      chk(g, "dsp_ce_ab", 32'(ceab[g]), 32'(e_ab));
      chk(g, "dsp_ce_m", 32'(cem[g]), 32'(e_m));
      chk(g, "dsp_ce_p", 32'(cep[g]), 32'(e_p));
      chk(g, "dsp_opmode", 32'(opm[g]), 32'(e_op));
      chk(g, "res_valid", 32'(rv[g]), 32'(e_rv));
      chk(g, "res_taps", 32'(rtaps[g]), 32'(e_taps));
    end
  end

  // Scoreboard: slice P at each result handshake against the expected sum.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (!rst[g] && rv[g] && rr[g]) begin
        if (exp_q.size() == 0) chk(g, "p_sum_no_expect", p_w[g], 32'hFFFF_FFFF);
        else                   chk(g, "p_sum", p_w[g], exp_q.pop_front());
      end
    end
  end

  // Driver: called at #1 after a posedge with the instance idle.
  task automatic run_job(input int g, input logic [7:0] base, input logic [7:0] len, input int hold);
    addr_log.delete();
    saw_m_o  = 1'b0;
    sv[g]    = 1'b1;
    sbase[g] = base;
    slen[g]  = len;
    @(posedge clk); #1;
    lat_o = 1;
    while (!rv[g] && lat_o < 1000) begin
      if (mrd[g]) addr_log.push_back(maddr[g]);
      if (cem[g]) saw_m_o = 1'b1;
      // Descriptors offered while busy must be ignored.
      sv[g]    = 1'($urandom_range(0, 1));
      sbase[g] = 8'($urandom_range(0, 255));
      slen[g]  = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
      lat_o++;
    end
    chk(g, "res_valid_timeout", 32'(lat_o < 1000), 32'd1);
    p_o    = p_w[g];
    taps_o = rtaps[g];
    for (int i = 0; i < hold; i++) begin
      sv[g] = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    sv[g] = 1'b0;
    rr[g] = 1'b1;
    @(posedge clk); #1;
    rr[g] = 1'b0;
  endtask

  task automatic chk_addrs(input int g, input string nm, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3, input int n);
    logic [7:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    chk(g, {nm, "_count"}, 32'(addr_log.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      chk(g, nm, (i < addr_log.size()) ? 32'(addr_log[i]) : 32'hDEAD, 32'(e[i]));
    end
  endtask

  initial begin
    rst = 2'b11; sv = '0; rr = '0; sbase = '0; slen = '0;
    for (int i = 0; i < 256; i++) begin
      a_mem[i] = 8'($urandom_range(0, 255));
      b_mem[i] = 8'($urandom_range(0, 255));
    end
    a_mem[8'h10] = 8'd2; b_mem[8'h10] = 8'd3;
    a_mem[8'h11] = 8'd4; b_mem[8'h11] = 8'd5;
    a_mem[8'h12] = 8'd6; b_mem[8'h12] = 8'd7;

    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      chk(g, "reset_start_ready", 32'(sr[g]), 32'd1);
      chk(g, "reset_busy", 32'(busy[g]), 32'd0);
      chk(g, "reset_ce", 32'({ceab[g], cem[g], cep[g], rstp[g], mrd[g], rv[g]}), 32'd0);
      chk(g, "reset_opmode", 32'(opm[g]), 32'd0);
    end
    rst = 2'b00;
    @(posedge clk); #1;

    // Basic job, MREG=1: operands (2,3),(4,5),(6,7).
    run_job(0, 8'h10, 8'd3, 0);
    chk(0, "basic_latency", 32'(lat_o), 32'd8);
    chk(0, "basic_p", p_o, 32'd68);
    chk(0, "basic_taps", 32'(taps_o), 32'd3);
    chk_addrs(0, "basic_addr", 8'h10, 8'h11, 8'h12, 8'h00, 3);

    // Address wrap.
    run_job(0, 8'hFE, 8'd4, 0);
    chk(0, "wrap_latency", 32'(lat_o), 32'd9);
    chk_addrs(0, "wrap_addr", 8'hFE, 8'hFF, 8'h00, 8'h01, 4);

    // Zero-length job.
    run_job(0, 8'h33, 8'd0, 0);
    chk(0, "zero_latency", 32'(lat_o), 32'd2);
    chk(0, "zero_p", p_o, 32'd0);
    chk(0, "zero_reads", 32'(addr_log.size()), 32'd0);

    // MREG=0 build.
    run_job(1, 8'h10, 8'd3, 0);
    chk(1, "mreg0_latency", 32'(lat_o), 32'd7);
    chk(1, "mreg0_p", p_o, 32'd68);
    chk(1, "mreg0_ce_m_seen", 32'(saw_m_o), 32'd0);

    // Backpressure with ignored start pulses.
    run_job(0, 8'h20, 8'd5, 5);
    chk(0, "bp_taps", 32'(taps_o), 32'd5);
    chk(0, "bp_idle_after", 32'(sr[0]), 32'd1);

    // Reset mid-job, during FETCH idx=2 of a 6-tap job.
    sv[0] = 1'b1; sbase[0] = 8'h40; slen[0] = 8'd6;
    @(posedge clk); #1;
    sv[0] = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk(0, "midjob_addr", 32'(maddr[0]), 32'h42);
    rst[0] = 1'b1;
    #1;
    chk(0, "midjob_rst_outs", 32'({mrd[0], ceab[0], cem[0], cep[0], busy[0]}), 32'd0);
    chk(0, "midjob_rst_ready", 32'(sr[0]), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    @(posedge clk); #1;
    run_job(0, 8'h10, 8'd3, 1);
    chk(0, "after_reset_p", p_o, 32'd68);

    // Random jobs on both builds.
    for (int j = 0; j < 40; j++) begin
      int g;
      logic [7:0] b, l;
      g = $urandom_range(0, 1);
      b = 8'($urandom_range(0, 255));
      l = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(20, 60)) : 8'($urandom_range(0, 12));
      run_job(g, b, l, $urandom_range(0, 4));
    end
    chk(0, "exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
